// File: rtl/click_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// click_rr_arbiter_if
//   Bundle of the 2-phase handshake and status signals around
//   click_rr_arbiter.
//
//   master : environment side. Drives the input requests, their payloads and
//            the shared output acknowledge.
//   slave  : arbiter side. Drives the input acknowledges, the shared output
//            request and payload, and the status outputs.
//
//   Signals
//     in_req     [N_IN]            per-channel 2-phase request
//     in_ack     [N_IN]            per-channel 2-phase acknowledge
//     in_data    [N_IN*DATA_WIDTH] channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//     out_req                      shared output 2-phase request
//     out_ack                      shared output 2-phase acknowledge
//     out_data   [DATA_WIDTH]      payload of the granted channel
//     grant_idx  [clog2(N_IN)]     last or current granted channel
//     busy                         a transfer is outstanding on the output
//     xfer_count [16]              completed transfers, wrapping
// -----------------------------------------------------------------------------
interface click_rr_arbiter_if #(
    parameter int N_IN       = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = $clog2(N_IN);

    logic [N_IN-1:0]            in_req;
    logic [N_IN-1:0]            in_ack;
    logic [N_IN*DATA_WIDTH-1:0] in_data;
    logic                       out_req;
    logic                       out_ack;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [IDX_W-1:0]           grant_idx;
    logic                       busy;
    logic [15:0]                xfer_count;

    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, grant_idx, busy, xfer_count
    );

    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, grant_idx, busy, xfer_count
    );
endinterface

// File: rtl/click_rr_arbiter.sv
// -----------------------------------------------------------------------------
// click_rr_arbiter
//   Round-robin merge of N_IN 2-phase (transition-signalling) input channels
//   onto one shared 2-phase output. Everything is sampled on clk; the
//   handshake signals must already be synchronous to clk.
//
//   A channel holds a token while in_req[i] != in_ack[i]. In IDLE the first
//   token at or after rr_ptr is granted: its payload is captured, out_req
//   toggles and the FSM waits for out_ack to match out_req. The following
//   edge acknowledges the granted channel, advances rr_ptr past it and
//   returns to IDLE, so each transfer takes at least two clocks.
//
//   Ports
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : click_rr_arbiter_if.slave (handshakes, payloads, status)
// -----------------------------------------------------------------------------
module click_rr_arbiter #(
    parameter int              N_IN           = 4,
    parameter int              DATA_WIDTH     = 8,
    parameter logic [N_IN-1:0] PHASE_INIT_IN  = '0,
    parameter logic            PHASE_INIT_OUT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    click_rr_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [N_IN-1:0]       in_ack_q, in_ack_d;
    logic                  out_req_q, out_req_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  busy_q, busy_d;
    logic [15:0]           xfer_count_q, xfer_count_d;

    logic [N_IN-1:0]       tokens;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand;
    logic                  out_done;

    assign tokens   = bus.in_req ^ in_ack_q;
    assign out_done = (bus.out_ack == out_req_q);

    // Rotating priority search. Scanning from the far end back towards
    // rr_ptr lets the last hit (the one nearest rr_ptr) win.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_IN);
            if (tokens[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // State register. The payload register carries no storage array, so
    // every register, out_data included, gets a defined reset value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            in_ack_q     <= PHASE_INIT_IN;
            out_req_q    <= PHASE_INIT_OUT;
            out_data_q   <= '0;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ack_q     <= in_ack_d;
            out_req_q    <= out_req_d;
            out_data_q   <= out_data_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // Next-state logic. out_ack activity in IDLE is ignored, and the
    // completion edge always lands in IDLE, so a new grant can only happen
    // one edge later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (sel_valid) state_d = WAIT_ACK;
            WAIT_ACK: if (out_done)  state_d = IDLE;
        endcase
    end

    // Output/datapath logic. Inputs are not looked at in WAIT_ACK, which
    // keeps out_data and grant_idx frozen until the transfer completes.
    always_comb begin
        in_ack_d     = in_ack_q;
        out_req_d    = out_req_q;
        out_data_d   = out_data_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        busy_d       = busy_q;
        xfer_count_d = xfer_count_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    out_data_d  = bus.in_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    grant_idx_d = sel_idx;
                    out_req_d   = ~out_req_q;
                    busy_d      = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (out_done) begin
                    in_ack_d     = in_ack_q ^ (N_IN'(1) << grant_idx_q);
                    rr_ptr_d     = (grant_idx_q == IDX_W'(N_IN - 1)) ? '0
                                                                     : grant_idx_q + 1'b1;
                    busy_d       = 1'b0;
                    xfer_count_d = xfer_count_q + 16'd1;
                end
            end
        endcase
    end

    assign bus.in_ack     = in_ack_q;
    assign bus.out_req    = out_req_q;
    assign bus.out_data   = out_data_q;
    assign bus.grant_idx  = grant_idx_q;
    assign bus.busy       = busy_q;
    assign bus.xfer_count = xfer_count_q;
endmodule
